// File: rtl/bcd3_to_bin_if.sv
// Handshake and result bus for the three-digit BCD to binary converter.
// The converter sits on the slave side; the digit-entry logic drives the master side.
interface bcd3_to_bin_if;
  logic        start_i;
  logic [11:0] bcd_i;
  logic        ready_o;
  logic        valid_o;
  logic [9:0]  bin_o;
  logic        err_o;
  logic        clamped_o;

  modport master (
    output start_i,
    output bcd_i,
    input  ready_o,
    input  valid_o,
    input  bin_o,
    input  err_o,
    input  clamped_o
  );

  modport slave (
    input  start_i,
    input  bcd_i,
    output ready_o,
    output valid_o,
    output bin_o,
    output err_o,
    output clamped_o
  );
endinterface

// File: rtl/bcd3_to_bin.sv
// Iterative three-digit BCD to 10-bit binary converter (acc = acc*10 + digit, one digit
// per cycle, hundreds first). Optional result clamping to [MIN_VAL, MAX_VAL] is built
// only when the macro BCD2BIN_CLAMP_EN is defined; otherwise clamped_o is tied low.
module bcd3_to_bin #(
  parameter int unsigned MIN_VAL = 30,
  parameter int unsigned MAX_VAL = 300
) (
  input logic           clk_i,
  input logic           rst_n_i,
  bcd3_to_bin_if.slave  bus
);

  if ((MIN_VAL > MAX_VAL) || (MAX_VAL > 999)) begin : gen_bad_params
    $error("bcd3_to_bin: require MIN_VAL <= MAX_VAL <= 999");
  end

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      state_q;
  logic [11:0] digits_q;
  logic [9:0]  acc_q;
  logic [1:0]  cnt_q;
  logic        bad_q;
  logic        ready_q;
  logic        valid_q;
  logic [9:0]  bin_q;
  logic        err_q;
  logic        clamped_q;

  logic [3:0]  digit;
  logic [9:0]  acc_nxt;
  logic [9:0]  res_bin;
  logic        res_clamped;
  logic        bcd_bad;

  // Select the current digit and form the next accumulator value (wraps mod 1024).
  always_comb begin
    digit = digits_q[3:0];
    case (cnt_q)
      2'd0:    digit = digits_q[11:8];
      2'd1:    digit = digits_q[7:4];
      default: digit = digits_q[3:0];
    endcase
    // acc*10 = acc*8 + acc*2
    acc_nxt = {acc_q[6:0], 3'b000} + {acc_q[8:0], 1'b0} + {6'd0, digit};
    bcd_bad = (bus.bcd_i[11:8] > 4'd9) || (bus.bcd_i[7:4] > 4'd9) || (bus.bcd_i[3:0] > 4'd9);
  end

`ifdef BCD2BIN_CLAMP_EN
  localparam logic [9:0] MinV = 10'(MIN_VAL);
  localparam logic [9:0] MaxV = 10'(MAX_VAL);

  // Clamp the final accumulate in the same cycle it is produced.
  always_comb begin
    res_bin     = acc_nxt;
    res_clamped = 1'b0;
    if (acc_nxt < MinV) begin
      res_bin     = MinV;
      res_clamped = 1'b1;
    end else if (acc_nxt > MaxV) begin
      res_bin     = MaxV;
      res_clamped = 1'b1;
    end
  end
`else
  // No clamping: the final accumulate is the result.
  always_comb begin
    res_bin     = acc_nxt;
    res_clamped = 1'b0;
  end
`endif

  // Converter FSM with registered handshake and result outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      digits_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      bad_q     <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bin_q     <= '0;
      err_q     <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            digits_q <= bus.bcd_i;
            bad_q    <= bcd_bad;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= StConv;
          end
        end
        StConv: begin
          acc_q <= acc_nxt;
          cnt_q <= 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd2) begin
            state_q <= StDone;
            valid_q <= 1'b1;
            if (bad_q) begin
              bin_q     <= '0;
              err_q     <= 1'b1;
              clamped_q <= 1'b0;
            end else begin
              bin_q     <= res_bin;
              err_q     <= 1'b0;
              clamped_q <= res_clamped;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.valid_o   = valid_q;
  assign bus.bin_o     = bin_q;
  assign bus.err_o     = err_q;
  assign bus.clamped_o = clamped_q;

endmodule

// File: tb/tb_bcd3_to_bin.sv
// Self-checking bench for bcd3_to_bin: directed cases plus randomized digits checked
// against a decimal reference model. Honours BCD2BIN_CLAMP_EN like the design.
module tb_bcd3_to_bin;
  localparam int unsigned MIN_VAL = 30;
  localparam int unsigned MAX_VAL = 300;

  logic clk_i;
  logic rst_n_i;
  bcd3_to_bin_if bus ();

  bcd3_to_bin #(
    .MIN_VAL (MIN_VAL),
    .MAX_VAL (MAX_VAL)
  ) u_dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Decimal reading of three BCD digits, with error and optional clamp rules.
  function automatic void ref_model(input logic [11:0] b, output int bin, output int err,
                                    output int cl);
    int h, t, o, v;
    h = int'(b[11:8]);
    t = int'(b[7:4]);
    o = int'(b[3:0]);
    cl = 0;
    if (h > 9 || t > 9 || o > 9) begin
      bin = 0;
      err = 1;
    end else begin
      v   = h * 100 + t * 10 + o;
      err = 0;
`ifdef BCD2BIN_CLAMP_EN
      if (v < int'(MIN_VAL)) begin
        v  = int'(MIN_VAL);
        cl = 1;
      end else if (v > int'(MAX_VAL)) begin
        v  = int'(MAX_VAL);
        cl = 1;
      end
`endif
      bin = v;
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready_o && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    if (!bus.ready_o) check_eq("ready_timeout", 0, 1);
  endtask

  // One full conversion with latency, result and handshake checks.
  task automatic do_conv(input logic [11:0] b, input string tag);
    int exp_bin, exp_err, exp_cl, lat;
    ref_model(b, exp_bin, exp_err, exp_cl);
    wait_ready();
    bus.start_i = 1'b1;
    bus.bcd_i   = b;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.bcd_i   = 12'($urandom);
    lat = 0;
    while (!bus.valid_o && lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq({tag, "_latency"}, lat, 3);
    check_eq({tag, "_bin"}, int'(bus.bin_o), exp_bin);
    check_eq({tag, "_err"}, int'(bus.err_o), exp_err);
    check_eq({tag, "_clamped"}, int'(bus.clamped_o), exp_cl);
    check_eq({tag, "_ready_low"}, int'(bus.ready_o), 0);
    @(negedge clk_i);
    check_eq({tag, "_ready_back"}, int'(bus.ready_o), 1);
    check_eq({tag, "_valid_once"}, int'(bus.valid_o), 0);
  endtask

  function automatic logic [3:0] rand_nib();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    int pulses, first_t, second_t, first_bin, second_bin;
    logic [11:0] rb;

    bus.start_i = 1'b0;
    bus.bcd_i   = '0;
    rst_n_i     = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_ready", int'(bus.ready_o), 1);
    check_eq("rst_valid", int'(bus.valid_o), 0);
    check_eq("rst_bin", int'(bus.bin_o), 0);
    check_eq("rst_err", int'(bus.err_o), 0);
    check_eq("rst_clamped", int'(bus.clamped_o), 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    do_conv(12'h123, "c123");

    // Back-to-back with start held high.
    wait_ready();
    bus.start_i = 1'b1;
    bus.bcd_i   = 12'h999;
    @(negedge clk_i);
    bus.bcd_i = 12'h000;
    pulses = 0; first_t = -1; second_t = -1; first_bin = -1; second_bin = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_i);
      if (bus.valid_o) begin
        check_eq("b2b_no_ready_with_valid", int'(bus.ready_o), 0);
        if (pulses == 0) begin first_t = i; first_bin = int'(bus.bin_o); end
        else if (pulses == 1) begin second_t = i; second_bin = int'(bus.bin_o); end
        pulses++;
      end
    end
    bus.start_i = 1'b0;
    check_eq("b2b_pulses", pulses, 2);
    check_eq("b2b_first_time", first_t, 3);
    check_eq("b2b_spacing", second_t - first_t, 5);
    check_eq("b2b_bin999", first_bin, 999);
    check_eq("b2b_bin000", second_bin, 0);
    repeat (6) @(negedge clk_i);

    do_conv(12'h1A3, "c1A3");
    do_conv(12'h042, "c042");

    // Start while busy is ignored.
    wait_ready();
    bus.start_i = 1'b1;
    bus.bcd_i   = 12'h250;
    @(negedge clk_i);
    bus.bcd_i = 12'h777;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    pulses = 0; first_bin = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus.valid_o) begin
        pulses++;
        first_bin = int'(bus.bin_o);
      end
      @(negedge clk_i);
    end
    check_eq("busy_pulses", pulses, 1);
    check_eq("busy_bin", first_bin, 250);

    // Reset in the middle of a conversion.
    wait_ready();
    bus.start_i = 1'b1;
    bus.bcd_i   = 12'h555;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check_eq("midrst_ready", int'(bus.ready_o), 1);
    check_eq("midrst_bin", int'(bus.bin_o), 0);
    check_eq("midrst_valid", int'(bus.valid_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (bus.valid_o) pulses++;
    end
    check_eq("midrst_no_valid", pulses, 0);
    do_conv(12'h010, "c010");

    // Clamp boundaries (expectations follow the build's clamp setting).
    do_conv(12'h020, "c020");
    do_conv(12'h450, "c450");
    do_conv(12'h120, "c120");
    do_conv(12'h030, "c030");
    do_conv(12'h300, "c300");
    do_conv(12'h301, "c301");

    for (int i = 0; i < 25; i++) begin
      rb = {rand_nib(), rand_nib(), rand_nib()};
      do_conv(rb, $sformatf("rnd%0d_%03h", i, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
